// File: rtl/prog_inst_memory.sv
// prog_inst_memory: instruction memory with a registered fetch port and a
// byte-serial program loader.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   pc, fetch_en          fetch byte address (word index pc[AW+1:2]); 0 = stall
//   instruction           registered instruction word
//   inst_valid            instruction holds a real fetched word
//   addr_fault            registered out-of-range fetch flag
//   load_start/load_end   pulses that enter/leave program-load mode
//   load_byte/load_valid  program bytes, most significant byte of a word first
//   busy                  high while loading
//   load_ovf              sticky: bytes dropped because memory was full
//
// Build option: define IMEM_BOUNDS_TRAP_EN to drive addr_fault from the
// out-of-range compare. Without it addr_fault is tied low.
//
// mem_q has no reset. Its power-up image is expected to be RESET_INST,
// which is the device default for the default RESET_INST of zero.
//
// state     | meaning
// ST_IDLE   | fetch port live, loader waiting for load_start
// ST_LOAD   | collecting bytes into the word assembler
// ST_COMMIT | one cycle writing the assembled word, then back to ST_LOAD

module prog_inst_memory #(
  parameter int          DEPTH      = 128,
  parameter int          AW         = $clog2(DEPTH),
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic        addr_fault,
  input  logic        load_start,
  input  logic [7:0]  load_byte,
  input  logic        load_valid,
  input  logic        load_end,
  output logic        busy,
  output logic        load_ovf
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Pointer is one bit wider than a word index so it can hold DEPTH (full).
  localparam logic [AW:0] FULL_PTR = (AW+1)'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        ovf_q, ovf_d;
  logic        mem_we;

  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic [31:0] mem_q [DEPTH];

  logic          busy_w;
  logic          oor;
  logic [AW-1:0] idx;

  assign busy_w = (state_q != ST_IDLE);
  assign idx    = pc[AW+1:2];
  assign oor    = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // load_end in the same cycle as load_start is ignored: start wins.
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_end) begin
          // Any partial word in the assembler is abandoned.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (load_valid) begin
          if (ptr_q == FULL_PTR) begin
            ovf_d = 1'b1;
          end else begin
            asm_d = {asm_q[23:0], load_byte};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        // The write always completes; a load_end seen here exits right after it.
        mem_we  = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        state_d = load_end ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q[AW-1:0]] <= asm_q;
  end

  always_comb begin
    inst_d  = inst_q;
    valid_d = valid_q;
    if (fetch_en) begin
      if (busy_w) begin
        inst_d  = RESET_INST;
        valid_d = 1'b0;
      end else if (oor) begin
        inst_d  = RESET_INST;
        valid_d = 1'b1;
      end else begin
        inst_d  = mem_q[idx];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q  <= RESET_INST;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

`ifdef IMEM_BOUNDS_TRAP_EN
  logic fault_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         fault_q <= 1'b0;
    else if (fetch_en) fault_q <= oor;
  end
  assign addr_fault = fault_q;
`else
  assign addr_fault = 1'b0;
`endif

  assign instruction = inst_q;
  assign inst_valid  = valid_q;
  assign busy        = busy_w;
  assign load_ovf    = ovf_q;

endmodule

// File: tb/tb_prog_inst_memory.sv
module tb_prog_inst_memory;

  localparam logic [31:0] RI = 32'h0000_0000;
  localparam int DA = 128;
  localparam int DB = 16;
`ifdef IMEM_BOUNDS_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        fetch_en = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_valid = 1'b0;
  logic        load_end = 1'b0;
  logic        chk = 1'b0;

  logic [31:0] inst_a, inst_b;
  logic        valid_a, valid_b, fault_a, fault_b, busy_a, busy_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  prog_inst_memory #(.DEPTH(DA)) dut_a (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
    .instruction(inst_a), .inst_valid(valid_a), .addr_fault(fault_a),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid),
    .load_end(load_end), .busy(busy_a), .load_ovf(ovf_a)
  );

  prog_inst_memory #(.DEPTH(DB)) dut_b (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
    .instruction(inst_b), .inst_valid(valid_b), .addr_fault(fault_b),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid),
    .load_end(load_end), .busy(busy_b), .load_ovf(ovf_b)
  );

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        fault;
    logic        busy;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: memory images, held outputs, and the bytes of the
  // current load session (words are committed when the session ends).
  logic [31:0] mem_a [DA];
  logic [31:0] mem_b [DB];
  logic [31:0] h_inst_a, h_inst_b;
  logic        h_valid_a, h_valid_b, h_fault_a, h_fault_b;
  bit          m_busy;
  bit          m_ovf_a, m_ovf_b;
  logic [7:0]  sess[$];

  function automatic bit in_range(input logic [31:0] p, input int depth);
    return (p[1:0] == 2'b00) && ((p >> 2) < 32'(depth));
  endfunction

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 15)) << 2;
      1:       return 32'($urandom_range(0, 127)) << 2;
      2:       return (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
      3:       return $urandom();
      default: return 32'($urandom_range(128, 1023)) << 2;
    endcase
  endfunction

  task automatic commit_session();
    int nw;
    nw = sess.size() / 4;
    for (int k = 0; k < nw; k++) begin
      logic [31:0] w;
      w = {sess[4*k], sess[4*k+1], sess[4*k+2], sess[4*k+3]};
      if (k < DA) mem_a[k] = w;
      if (k < DB) mem_b[k] = w;
    end
    sess.delete();
  endtask

  task automatic drive(input logic fe, input logic [31:0] p, input logic ls,
                       input logic lv, input logic [7:0] lb, input logic le,
                       input logic c);
    bit ia, ib;
    @(negedge clk);
    fetch_en = fe; pc = p; load_start = ls; load_valid = lv;
    load_byte = lb; load_end = le; chk = c;
    if (fe) begin
      ia = in_range(p, DA);
      ib = in_range(p, DB);
      h_fault_a = TRAP ? !ia : 1'b0;
      h_fault_b = TRAP ? !ib : 1'b0;
      if (m_busy) begin
        h_inst_a = RI; h_valid_a = 1'b0;
        h_inst_b = RI; h_valid_b = 1'b0;
      end else begin
        h_inst_a = ia ? mem_a[p >> 2] : RI; h_valid_a = 1'b1;
        h_inst_b = ib ? mem_b[p >> 2] : RI; h_valid_b = 1'b1;
      end
    end
    if (!m_busy) begin
      if (ls) begin
        m_busy = 1'b1; m_ovf_a = 1'b0; m_ovf_b = 1'b0; sess.delete();
      end
    end else if (le) begin
      commit_session();
      m_busy = 1'b0;
    end else if (lv) begin
      sess.push_back(lb);
      if (sess.size() > 4*DA) m_ovf_a = 1'b1;
      if (sess.size() > 4*DB) m_ovf_b = 1'b1;
    end
    if (c) begin
      q_a.push_back('{h_inst_a, h_valid_a, h_fault_a, m_busy, m_ovf_a});
      q_b.push_back('{h_inst_b, h_valid_b, h_fault_b, m_busy, m_ovf_b});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    fetch_en = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; chk = 1'b0;
    if (m_busy) commit_session();
    m_busy = 1'b0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    h_inst_a = RI; h_valid_a = 1'b0; h_fault_a = 1'b0;
    h_inst_b = RI; h_valid_b = 1'b0; h_fault_b = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rnd_fetch(input bit rnd, output logic fe, output logic [31:0] p);
    fe = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    p  = rnd ? rand_pc() : 32'h0;
  endtask

  // end_mode: 0 = load_end in its own cycle, 1 = load_end in the first gap
  // after the last byte (COMMIT when the word completes), 2 = no load_end.
  task automatic load_seq(input logic [7:0] bs[$], input bit rnd, input int end_mode);
    logic fe, le, ls;
    logic [31:0] p;
    int ng;
    bit done;
    done = 1'b0;
    rnd_fetch(rnd, fe, p);
    drive(fe, p, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    foreach (bs[i]) begin
      rnd_fetch(rnd, fe, p);
      drive(fe, p, 1'b0, 1'b1, bs[i], 1'b0, 1'b1);
      ng = rnd ? $urandom_range(1, 3) : 1;
      for (int g = 0; g < ng && !done; g++) begin
        le = (end_mode == 1) && (i == bs.size() - 1) && (g == 0);
        ls = rnd && ($urandom_range(0, 7) == 0);
        rnd_fetch(rnd, fe, p);
        drive(fe, p, ls, 1'b0, 8'h00, le, 1'b1);
        if (le) done = 1'b1;
      end
    end
    if (end_mode == 0 || (end_mode == 1 && !done)) begin
      rnd_fetch(rnd, fe, p);
      drive(fe, p, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  bit chk_s = 1'b0;
  always @(posedge clk) chk_s <= chk;

  always @(negedge clk) begin
    if (chk_s) begin
      if (q_a.size() == 0 || q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard at %0t: output presented, got no expected entry, expected one", $time);
      end else begin
        exp_t ea, eb;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        cmp("a.instruction", inst_a, ea.inst);
        cmp("a.inst_valid", 32'(valid_a), 32'(ea.valid));
        cmp("a.addr_fault", 32'(fault_a), 32'(ea.fault));
        cmp("a.busy", 32'(busy_a), 32'(ea.busy));
        cmp("a.load_ovf", 32'(ovf_a), 32'(ea.ovf));
        cmp("b.instruction", inst_b, eb.inst);
        cmp("b.inst_valid", 32'(valid_b), 32'(eb.valid));
        cmp("b.addr_fault", 32'(fault_b), 32'(eb.fault));
        cmp("b.busy", 32'(busy_b), 32'(eb.busy));
        cmp("b.load_ovf", 32'(ovf_b), 32'(eb.ovf));
      end
    end
  end

  initial begin
    logic [7:0] bs[$];
    logic [7:0] prog8[$];
    logic fe;
    logic [31:0] p;

    for (int i = 0; i < DA; i++) mem_a[i] = RI;
    for (int i = 0; i < DB; i++) mem_b[i] = RI;
    h_inst_a = RI; h_valid_a = 1'b0; h_fault_a = 1'b0;
    h_inst_b = RI; h_valid_b = 1'b0; h_fault_b = 1'b0;
    m_busy = 1'b0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Two-word program, then fetch both words.
    prog8 = '{8'h20, 8'h1D, 8'h00, 8'h00, 8'h3C, 8'h08, 8'h40, 8'h00};
    load_seq(prog8, 1'b0, 0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Stall: outputs hold while pc wanders.
    for (int i = 0; i < 3; i++) drive(1'b0, $urandom(), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Out of range (past DEPTH=128) and misaligned.
    drive(1'b1, 32'h200, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Partial word: 5 bytes, then load_end.
    bs = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    load_seq(bs, 1'b0, 0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // 17 words: fills DEPTH=16 and overflows it, with load_end during COMMIT.
    bs.delete();
    for (int i = 0; i < 68; i++) bs.push_back(8'($urandom()));
    load_seq(bs, 1'b0, 1);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h40, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // load_start and load_end together in IDLE enter load mode.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a 6-byte load.
    bs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    load_seq(bs, 1'b0, 2);
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Random mix of fetches, loads and aborted loads.
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          rnd_fetch(1'b1, fe, p);
          drive(fe, p, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        3, 4: begin
          bs.delete();
          repeat ($urandom_range(0, 14)) bs.push_back(8'($urandom()));
          load_seq(bs, 1'b1, $urandom_range(0, 1));
        end
        default: begin
          bs.delete();
          repeat ($urandom_range(1, 10)) bs.push_back(8'($urandom()));
          load_seq(bs, 1'b1, 2);
          do_reset();
        end
      endcase
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_vec++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
